// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 16;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  // Saturate a raw nibble to a legal BCD digit.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One-digit BCD decrement stage, chained through borrow to form a multi-digit
// decrementer.
//   digit        current BCD digit
//   borrow_in    1 = subtract one from this digit
//   dec_c        resulting digit (combinational)
//   borrow_out   1 = this digit wrapped 0 -> 9 and borrows from the next digit
module bcd_digit_dec
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] dec_c,
  output logic               borrow_out
);

  always_comb begin
    dec_c      = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        dec_c      = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        dec_c = digit - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer with prescaled tick, pause/resume and expiry.
//   clk, rst_n        clock, synchronous active-low reset
//   load, load_val    load packed BCD value (nibbles > 9 saturate to 9), go IDLE
//   start, pause      start/resume and suspend pulses (priority load > pause > start)
//   digit0..digit3    registered count, digit0 least significant
//   running, expired  registered state flags
//   done              one-cycle pulse when the count reaches 0000
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BCD_W-1:0]   load_val,
  input  logic               start,
  input  logic               pause,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic               running,
  output logic               expired,
  output logic               done
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  timer_state_t state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] count_q, count_d, dec_val, load_clamped;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             running_d, expired_d, done_d;
  logic [NUM_DIGITS:0] borrow;

  // Borrow chain: subtract one from the whole count.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (count_q[i]),
      .borrow_in  (borrow[i]),
      .dec_c      (dec_val[i]),
      .borrow_out (borrow[i+1])
    );
    assign load_clamped[i] = bcd_clamp(load_val[i*DIGIT_W +: DIGIT_W]);
  end

  // State, count, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      running <= running_d;
      expired <= expired_d;
      done    <= done_d;
    end
  end

  // Next-state, count and prescaler logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_clamped;
      pre_d   = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start && (count_q != '0)) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          // A pause on a tick edge wins; the prescaler stays at PRE_LAST so the
          // deferred decrement fires on the first cycle after resume.
          if (pause) begin
            state_d = PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            // borrow out of the top digit means the count is already 0000
            if (!borrow[NUM_DIGITS]) begin
              count_d = dec_val;
              if (dec_val == '0) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
              end
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        PAUSED: begin
          if (!pause && start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  assign digit0 = count_q[0];
  assign digit1 = count_q[1];
  assign digit2 = count_q[2];
  assign digit3 = count_q[3];

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with an integer-level reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n, load, start, pause;
  logic [15:0] load_val;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        running, expired, done;

  bcd_countdown_timer #(.TICK_CYCLES(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: count as a plain integer 0..9999.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
  int m_cnt   = 0;
  int m_pre   = 0;
  int m_state = M_IDLE;
  bit m_done  = 1'b0;

  function automatic int clamp_to_int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void model_step(input bit r, input bit ld, input logic [15:0] lv,
                                     input bit st, input bit pa);
    m_done = 1'b0;
    if (!r) begin
      m_cnt = 0; m_pre = 0; m_state = M_IDLE;
    end else if (ld) begin
      m_cnt = clamp_to_int(lv); m_pre = 0; m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (!pa && st && m_cnt != 0) begin m_state = M_RUN; m_pre = 0; end
    end else if (m_state == M_RUN) begin
      if (pa) m_state = M_PAUSED;
      else if (m_pre == int'(T) - 1) begin
        m_pre = 0;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_state = M_EXPIRED; m_done = 1'b1; end
      end else m_pre = m_pre + 1;
    end else if (m_state == M_PAUSED) begin
      if (!pa && st) m_state = M_RUN;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model's expectation is queued at the edge.
  task automatic cycle(input bit r, input bit ld, input logic [15:0] lv,
                       input bit st, input bit pa);
    obs_t e;
    @(negedge clk);
    rst_n = r; load = ld; load_val = lv; start = st; pause = pa;
    @(posedge clk);
    model_step(r, ld, lv, st, pa);
    e.digits  = int_to_bcd(m_cnt);
    e.running = (m_state == M_RUN);
    e.expired = (m_state == M_EXPIRED);
    e.done    = m_done;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 16'h0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    forever begin
      obs_t e, g;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '{digits: {digit3, digit2, digit1, digit0}, running: running,
              expired: expired, done: done};
        chk("scoreboard", 32'(g), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
    cycle(0, 0, 16'h0, 0, 0);
    cycle(0, 0, 16'h0, 0, 0);
    #2 chk("reset state", {digit3, digit2, digit1, digit0, running, expired, done}, '0);

    // Reset mid-run
    cycle(1, 1, 16'h0042, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(6);
    cycle(0, 0, 16'h0, 0, 0);
    #2 chk("reset mid-run", {digit3, digit2, digit1, digit0, running, expired, done}, '0);
    idle(2);

    // Borrow chain
    cycle(1, 1, 16'h1000, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(4);
    #2 chk("borrow first", {digit3, digit2, digit1, digit0}, 32'h0999);
    idle(4);
    #2 chk("borrow second", {digit3, digit2, digit1, digit0}, 32'h0998);

    // Expiry
    cycle(1, 1, 16'h0002, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(4);
    #2 chk("expiry 0001", {digit3, digit2, digit1, digit0}, 32'h0001);
    idle(4);
    #2 chk("expiry edge", {digit3, digit2, digit1, digit0, running, expired, done}, {16'h0000, 3'b011});
    idle(1);
    #2 chk("done one cycle", {running, expired, done}, 3'b010);
    cycle(1, 0, 16'h0, 1, 0);
    idle(2);
    #2 chk("start in expired", {running, expired}, 2'b01);

    // Pause/resume
    cycle(1, 1, 16'h0005, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(2);
    cycle(1, 0, 16'h0, 0, 1);
    idle(10);
    #2 chk("held during pause", {digit3, digit2, digit1, digit0}, 32'h0005);
    cycle(1, 0, 16'h0, 1, 0);
    idle(2);
    #2 chk("resume decrement", {digit3, digit2, digit1, digit0}, 32'h0004);

    // Pause landing on a tick edge
    cycle(1, 1, 16'h0003, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(3);
    cycle(1, 0, 16'h0, 0, 1);
    idle(3);
    cycle(1, 0, 16'h0, 1, 0);
    idle(1);
    #2 chk("deferred tick", {digit3, digit2, digit1, digit0}, 32'h0002);
    idle(2);

    // Priority and clamping
    cycle(1, 1, 16'hA3F7, 1, 0);
    #2 chk("clamp+priority", {digit3, digit2, digit1, digit0, running, expired}, {16'h9397, 2'b00});
    idle(2);
    cycle(1, 1, 16'h0000, 0, 0);
    cycle(1, 0, 16'h0, 1, 0);
    idle(1);
    #2 chk("start at zero", {running, expired}, 2'b00);

    // Randomized traffic; small loads so expiry is reached often
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, st, pa;
      logic [15:0] lv;
      r  = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 4) == 0);
      pa = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      cycle(r, ld, lv, st, pa);
    end

    idle(2);
    @(posedge clk);
    #2 chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Four-digit BCD countdown timer that drives the seven-segment decoder stage. It holds a loadable value of 0000–9999 and decrements it once per prescaled tick while running. Each 4-bit digit output feeds one seven-segment decoder instance directly. Status outputs report running, expiry, and a one-cycle done pulse for the surrounding game/control logic.

## Interface
- TICK_CYCLES, 50_000_000, clock cycles per decrement (1 s at 50 MHz); legal range ≥ 1
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- load  in  1  pulse; load load_val into the count, go to IDLE
- load_val  in  16  packed BCD, digit3 in [15:12] … digit0 in [3:0]
- start  in  1  pulse; begin counting or resume from pause
- pause  in  1  pulse; suspend counting
- digit0..digit3  out  4 each  current BCD count, digit0 = least significant, registered
- running  out  1  high while state is RUN
- expired  out  1  high while state is EXPIRED
- done  out  1  one-cycle pulse on the RUN→EXPIRED transition

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Reset (rst_n = 0 at an edge):
  - digits = 0000, state = IDLE, prescaler = 0.
  - running = 0, expired = 0, done = 0.
  - Applies mid-count as well; no other input is honoured that cycle.
- Input priority in every state: load > pause > start.
- load, in any state: count ← load_val with each nibble > 9 clamped to 9; prescaler ← 0; state ← IDLE.
- IDLE:
  - start with count ≠ 0000 → RUN, prescaler ← 0.
  - start with count = 0000 is ignored.
  - pause is ignored.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler = TICK_CYCLES−1, it wraps to 0 and the count decrements by 1 in BCD.
  - pause → PAUSED; prescaler value is held, not cleared.
  - start is ignored.
- PAUSED: start → RUN, prescaler resumes from its held value.
- BCD decrement:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - The count never goes below 0000.
  - A decrement that yields 0000 moves the state to EXPIRED at the same edge.
- EXPIRED:
  - Count stays 0000.
  - start and pause are ignored.
  - Only load or reset leave this state.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- start sampled at edge k:
  - running = 1 from edge k.
  - First decrement at edge k+TICK_CYCLES.
  - Subsequent decrements every TICK_CYCLES edges.
- load sampled at edge k: digits show the new value from edge k.
- done:
  - High for exactly one cycle, starting at the edge where the count reaches 0000.
  - expired rises on that same edge; running falls on that same edge.
- A pause arriving on the same edge as a tick:
  - pause wins, so no decrement occurs.
  - The prescaler holds at TICK_CYCLES−1.
  - The deferred decrement happens one cycle after resume.
- TICK_CYCLES = 1: decrement every cycle while in RUN; prescaler width is at least 1 bit.

## Structure
- Package timer_pkg holds:
  - state enum timer_state_t {IDLE, RUN, PAUSED, EXPIRED};
  - constant BCD_MAX = 4'd9;
  - the packed-BCD width constant (16).
- Sub-module bcd_digit_dec: combinational one-digit decrement.
  - Ports: digit in, borrow_in, digit out, borrow_out.
  - Instantiated 4× in a borrow chain.
- Prescaler and FSM are in the top module.

## Test plan
Run all scenarios with TICK_CYCLES = 4.
- Reset mid-run: load 0042, start, wait 6 cycles, assert rst_n = 0 for one edge.
  - Required: digits 0000, running = 0, expired = 0, done = 0 on the following cycle.
- Borrow chain: load 1000, start.
  - First decrement 4 cycles after start; digits read 0999.
  - After 4 more cycles, digits read 0998.
- Expiry: load 0002, start.
  - Digits 0001 after 4 cycles.
  - Digits 0000 after 8 cycles, with done = 1 for exactly one cycle, expired = 1, running = 0.
  - A later start leaves the state EXPIRED.
- Pause/resume: load 0005, start, pause after 2 cycles, hold 10 cycles, start.
  - Required: digits stay 0005 throughout the pause.
  - Digits read 0004 exactly 2 cycles after resume.
- Priority and clamping:
  - Same-cycle load = 1, start = 1, load_val = 16'hA3F7: digits 9397, state IDLE, running = 0.
  - Start with load_val = 0000: ignored, running stays 0.
